// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: computes A - B - Bin one bit per clock, LSB first,
// and presents a registered difference and borrow-out with a one-cycle done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d;
    logic             busy_d;
    logic             done_d;

    // One-bit full-subtractor slice on the current LSBs of the operand shifters
    logic             d_bit;
    logic             br_nx;
    logic [WIDTH-1:0] res_shift;

    assign d_bit     = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nx     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign res_shift = {d_bit, res_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            br_q  <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            br_q  <= br_d;
            Diff  <= diff_d;
            Bout  <= bout_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = Diff;
        bout_d  = Bout;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_nx;
                res_d = res_shift;
                cnt_d = cnt_q + CNT_W'(1);
                // Last bit: publish the full result straight from the shifter input
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = res_shift;
                    bout_d  = br_nx;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
